gb_interrupt_controller: RTL and testbench
==========================================

# gb_interrupt_controller

Owns the IF (FF0F) and IE (FFFF) registers and arbitrates the five DMG interrupt sources. Sits directly downstream of `gb_timer` and the other peripheral blocks, and upstream of the CPU core. Collects single-cycle requests such as `irq_timer` into IF. Gives the CPU a pending flag for HALT wake and dispatch, and a registered vector/acknowledge handshake for interrupt service. IME is not stored here; it stays in the CPU.

## Interface
No parameters.
- `clk`  in  1  Machine (M) clock
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `data_i`  in  8  incoming data bus
- `addr`  in  16  address request
- `wren`  in  1  write to requested address
- `data_o`  out  8  value of requested register
- `irq_vblank`, `irq_stat`, `irq_timer`, `irq_serial`, `irq_joypad`  in  1 each  request inputs, IF bits 0..4
- `int_ack`  in  1  CPU dispatch acknowledge pulse, one cycle
- `int_pending`  out  1  `(IE[4:0] & IF[4:0]) != 0`
- `int_vector`  out  16  service address from the last acknowledge
- `int_vector_valid`  out  1  one-cycle strobe: `int_vector` was updated

## Operation
- **IF[4:0]:**
  - Any request input high in a cycle sets its bit at that posedge. The set is level-based; rising-edge shaping is the source block's job.
  - Next-state is `next_IF = ((wr_IF ? data_i[4:0] : IF) & ~ack_clr) | req[4:0]`.
  - A hardware request therefore beats both a CPU write of 0 and the dispatch clear in the same cycle.
- **IE[7:0]:** fully read/write at FFFF. Only bits [4:0] take part in arbitration.
- **Reads (combinational on `addr`):**
  - FF0F returns `{3'b111, IF[4:0]}`.
  - FFFF returns `IE`.
  - Any other address returns 8'hFF.
- **Priority:** lowest bit index wins. Vector is `16'h0040 + 8*index`, giving 0040/0048/0050/0058/0060.
- **FSM with two states, IDLE and VECTOR:**
  - **IDLE + `int_ack`:**
    - Arbitrate on the current registered `IE & IF`.
    - Latch the winning vector into `int_vector` and set `ack_clr` to the winner's one-hot, clearing that IF bit at the same posedge.
    - Go to VECTOR.
    - If nothing is pending at ack time (IE or IF changed after the CPU committed), latch 16'h0000, clear nothing, and still go to VECTOR.
  - **VECTOR:** `int_vector_valid` = 1. `int_ack` is ignored. Always return to IDLE next cycle.
  - **IDLE without ack:** hold state.
- `int_vector` holds its value between acknowledges.
- **Writes:** a CPU write to FF0F or FFFF in the same cycle as `int_ack` is applied at the same posedge. Arbitration uses the pre-write register values.

## Timing
- **Reset (async, active-low):** IF=0, IE=0, state=IDLE, `int_vector`=0, `int_vector_valid`=0. Consequently `int_pending`=0 and `data_o` follows `addr`.
- **Request to IF bit visible:** 1 cycle. A request at edge N is readable and drives `int_pending` after edge N.
- **`int_pending`:** combinational from registers; no extra latency.
- **`int_ack` at edge N:**
  - `int_vector` is valid after N.
  - `int_vector_valid` is high for exactly the cycle N..N+1.
  - The IF bit is clear after N.
- **Back-to-back acks:** an ack in the VECTOR cycle is dropped. The CPU spaces acks by at least 5 M-cycles, so this never occurs legally.
- **Reset mid-dispatch:** the FSM returns to IDLE immediately; the valid strobe is lost.

## Structure
- Package `gb_interrupt_pkg` holds:
  - source index enum (VBLANK=0 … JOYPAD=4)
  - vector constants
  - `ADDR_IF`=16'hFF0F, `ADDR_IE`=16'hFFFF
  - FSM state enum
- Sub-module `gb_irq_priority`: purely combinational. Input `logic [4:0] active`; outputs `logic [4:0] onehot`, `logic [15:0] vector`, `logic any`.
- Top level holds the registers, FSM and bus decode.

## Test plan
- Reset, write IE=8'h04, pulse `irq_timer` for 1 cycle → read FF0F = 8'hE4, `int_pending`=1 on the following cycle.
- IE=8'h1F, requests on bits 0 and 2, `int_ack` → `int_vector`=16'h0040, valid for 1 cycle, FF0F=8'hE4. Second ack 6 cycles later → 16'h0050, FF0F=8'hE0, `int_pending`=0.
- IE=8'h04, IF=8'h04, write FF0F=8'h00 in the same cycle as an `irq_timer` pulse → FF0F reads 8'hE4.
- IF bit 2 set and IE=0, `int_ack` → `int_vector`=16'h0000, valid strobe, IF unchanged (8'hE4).
- Assert `reset` low during the VECTOR cycle → `int_vector_valid`=0 and `int_vector`=0 immediately, FF0F=8'hE0, FFFF=8'h00.
- `int_ack` while in VECTOR → ignored; IF unchanged; `int_vector` unchanged.

Source files
------------

// File: rtl/gb_interrupt_pkg.sv
// Shared types and constants for the DMG interrupt controller.
package gb_interrupt_pkg;

    // Interrupt source index. The index is also the IF/IE bit position.
    typedef enum logic [2:0] {
        SRC_VBLANK = 3'd0,
        SRC_STAT   = 3'd1,
        SRC_TIMER  = 3'd2,
        SRC_SERIAL = 3'd3,
        SRC_JOYPAD = 3'd4
    } irq_src_e;

    localparam int unsigned NUM_SRC = 5;

    // Service addresses, one per source, spaced 8 bytes apart.
    localparam logic [15:0] VEC_VBLANK = 16'h0040;
    localparam logic [15:0] VEC_STAT   = 16'h0048;
    localparam logic [15:0] VEC_TIMER  = 16'h0050;
    localparam logic [15:0] VEC_SERIAL = 16'h0058;
    localparam logic [15:0] VEC_JOYPAD = 16'h0060;
    localparam logic [15:0] VEC_NONE   = 16'h0000;

    // Memory-mapped register addresses.
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Dispatch FSM: VECTOR is the single cycle in which int_vector_valid is high.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_VECTOR = 1'b1
    } irq_state_e;

    // Service address for a source index.
    function automatic logic [15:0] vector_of(input irq_src_e src);
        logic [15:0] v;
        case (src)
            SRC_VBLANK: v = VEC_VBLANK;
            SRC_STAT:   v = VEC_STAT;
            SRC_TIMER:  v = VEC_TIMER;
            SRC_SERIAL: v = VEC_SERIAL;
            SRC_JOYPAD: v = VEC_JOYPAD;
            default:    v = VEC_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gb_irq_priority.sv
// Fixed-priority selector: lowest pending bit index wins.
module gb_irq_priority
    import gb_interrupt_pkg::*;
(
    input  logic [4:0]  active,
    output logic [4:0]  onehot,
    output logic [15:0] vector,
    output logic        any
);

    // Scan from the highest index down so the lowest set bit is the final assignment.
    always_comb begin
        onehot = '0;
        vector = VEC_NONE;
        any    = |active;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                onehot = 5'd1 << i;
                vector = vector_of(irq_src_e'(i[2:0]));
            end
        end
    end

endmodule

// File: rtl/gb_interrupt_controller.sv
// IF/IE register file, bus decode and interrupt dispatch handshake.
//
// Handshake: the CPU raises int_ack for one cycle while the FSM is IDLE; the
// controller answers with int_vector_valid high for exactly the following
// cycle (VECTOR) and int_vector already updated. There is no back-pressure:
// an int_ack seen during VECTOR is dropped.
module gb_interrupt_controller
    import gb_interrupt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic [15:0] addr,
    input  logic        wren,
    output logic [7:0]  data_o,
    input  logic        irq_vblank,
    input  logic        irq_stat,
    input  logic        irq_timer,
    input  logic        irq_serial,
    input  logic        irq_joypad,
    input  logic        int_ack,
    output logic        int_pending,
    output logic [15:0] int_vector,
    output logic        int_vector_valid,
    output logic        dbg_state_o
);

    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [15:0] vector_q, vector_d;
    irq_state_e  state_q, state_d;

    logic [4:0]  req;
    logic [4:0]  active;
    logic [4:0]  win_onehot;
    logic [15:0] win_vector;
    logic        win_any;
    logic [4:0]  ack_clr;
    logic        wr_if;
    logic        wr_ie;

    assign req    = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
    assign wr_if  = wren && (addr == ADDR_IF);
    assign wr_ie  = wren && (addr == ADDR_IE);
    assign active = ie_q[4:0] & if_q;

    gb_irq_priority u_priority (
        .active (active),
        .onehot (win_onehot),
        .vector (win_vector),
        .any    (win_any)
    );

    // Dispatch FSM next-state: latch the winner on ack and clear its IF bit.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ack_clr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (int_ack) begin
                    // An empty winner (nothing pending) yields 0000 and clears nothing.
                    vector_d = win_any ? win_vector : VEC_NONE;
                    ack_clr  = win_onehot;
                    state_d  = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register next-state: hardware requests override both CPU write and ack clear.
    always_comb begin
        if_d = ((wr_if ? data_i[4:0] : if_q) & ~ack_clr) | req;
        ie_d = wr_ie ? data_i : ie_q;
    end

    // State and register update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            if_q     <= '0;
            ie_q     <= '0;
            vector_q <= VEC_NONE;
        end else begin
            state_q  <= state_d;
            if_q     <= if_d;
            ie_q     <= ie_d;
            vector_q <= vector_d;
        end
    end

    // Combinational read mux; unused IF bits read as 1.
    always_comb begin
        data_o = 8'hFF;
        if (addr == ADDR_IF) begin
            data_o = {3'b111, if_q};
        end else if (addr == ADDR_IE) begin
            data_o = ie_q;
        end
    end

    assign int_pending      = |active;
    assign int_vector       = vector_q;
    assign int_vector_valid = (state_q == ST_VECTOR);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_gb_interrupt_controller.sv
// Directed self-checking bench for gb_interrupt_controller.
module tb_gb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [7:0]  data_i;
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  data_o;
    logic        irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;
    logic        int_ack;
    logic        int_pending;
    logic [15:0] int_vector;
    logic        int_vector_valid;
    logic        dbg_state_o;

    int checks   = 0;
    int failures = 0;

    gb_interrupt_controller dut (
        .clk              (clk),
        .reset            (reset),
        .data_i           (data_i),
        .addr             (addr),
        .wren             (wren),
        .data_o           (data_o),
        .irq_vblank       (irq_vblank),
        .irq_stat         (irq_stat),
        .irq_timer        (irq_timer),
        .irq_serial       (irq_serial),
        .irq_joypad       (irq_joypad),
        .int_ack          (int_ack),
        .int_pending      (int_pending),
        .int_vector       (int_vector),
        .int_vector_valid (int_vector_valid),
        .dbg_state_o      (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one active edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        data_i = d;
        wren   = 1'b1;
        tick();
        wren   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, {8'h00, data_o}, {8'h00, exp});
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; data_i = '0; addr = '0; wren = 1'b0; int_ack = 1'b0;
        irq_vblank = 0; irq_stat = 0; irq_timer = 0; irq_serial = 0; irq_joypad = 0;
        tick(); tick();

        // reset state
        chk("rst_vector", int_vector, 16'h0000);
        chk("rst_valid", {15'd0, int_vector_valid}, 16'd0);
        chk("rst_pending", {15'd0, int_pending}, 16'd0);
        chk("rst_state", {15'd0, dbg_state_o}, 16'd0);
        rd("rst_if", 16'hFF0F, 8'hE0);
        rd("rst_ie", 16'hFFFF, 8'h00);
        rd("rst_other", 16'h1234, 8'hFF);
        reset = 1'b1;
        tick();

        // timer request into IF, pending follows
        cpu_write(16'hFFFF, 8'h04);
        irq_timer = 1'b1; tick(); irq_timer = 1'b0;
        rd("timer_if", 16'hFF0F, 8'hE4);
        chk("timer_pending", {15'd0, int_pending}, 16'd1);
        rd("ie_readback", 16'hFFFF, 8'h04);

        // priority: bits 0 and 2 pending, vblank wins
        cpu_write(16'hFFFF, 8'h1F);
        irq_vblank = 1'b1; tick(); irq_vblank = 1'b0;
        rd("two_if", 16'hFF0F, 8'hE5);
        ack();
        chk("ack1_vector", int_vector, 16'h0040);
        chk("ack1_valid", {15'd0, int_vector_valid}, 16'd1);
        rd("ack1_if", 16'hFF0F, 8'hE4);
        tick();
        chk("ack1_valid_drop", {15'd0, int_vector_valid}, 16'd0);
        chk("ack1_vector_hold", int_vector, 16'h0040);
        tick(); tick(); tick(); tick();
        ack();
        chk("ack2_vector", int_vector, 16'h0050);
        rd("ack2_if", 16'hFF0F, 8'hE0);
        chk("ack2_pending", {15'd0, int_pending}, 16'd0);
        tick();

        // ack during VECTOR is dropped
        irq_stat = 1'b1; irq_serial = 1'b1; tick(); irq_stat = 1'b0; irq_serial = 1'b0;
        ack();
        chk("stat_vector", int_vector, 16'h0048);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd("drop_if", 16'hFF0F, 8'hE8);
        chk("drop_vector", int_vector, 16'h0048);
        chk("drop_valid", {15'd0, int_vector_valid}, 16'd0);
        tick();
        ack();
        chk("serial_vector", int_vector, 16'h0058);
        rd("serial_if", 16'hFF0F, 8'hE0);
        tick();

        // joypad, with a fresh joypad request in the ack cycle keeping the bit set
        irq_joypad = 1'b1; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0; irq_joypad = 1'b0;
        chk("joy_vector", int_vector, 16'h0060);
        rd("joy_if_kept", 16'hFF0F, 8'hF0);
        tick();
        cpu_write(16'hFF0F, 8'h00);
        rd("if_write_clear", 16'hFF0F, 8'hE0);

        // request beats CPU write of 0
        cpu_write(16'hFFFF, 8'h04);
        cpu_write(16'hFF0F, 8'h04);
        addr = 16'hFF0F; data_i = 8'h00; wren = 1'b1; irq_timer = 1'b1;
        tick();
        wren = 1'b0; irq_timer = 1'b0;
        rd("req_beats_write", 16'hFF0F, 8'hE4);

        // nothing pending at ack (IE=0): vector 0000, IF untouched
        cpu_write(16'hFFFF, 8'h00);
        chk("none_pending", {15'd0, int_pending}, 16'd0);
        ack();
        chk("none_vector", int_vector, 16'h0000);
        chk("none_valid", {15'd0, int_vector_valid}, 16'd1);
        rd("none_if", 16'hFF0F, 8'hE4);
        tick();

        // write to IE in the ack cycle: arbitration sees the old IE
        cpu_write(16'hFFFF, 8'h04);
        addr = 16'hFFFF; data_i = 8'h00; wren = 1'b1; int_ack = 1'b1;
        tick();
        wren = 1'b0; int_ack = 1'b0;
        chk("prewrite_vector", int_vector, 16'h0050);
        rd("prewrite_if", 16'hFF0F, 8'hE0);
        rd("prewrite_ie", 16'hFFFF, 8'h00);
        tick();

        // reset during VECTOR
        cpu_write(16'hFFFF, 8'h04);
        irq_timer = 1'b1; tick(); irq_timer = 1'b0;
        ack();
        chk("prereset_valid", {15'd0, int_vector_valid}, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, int_vector_valid}, 16'd0);
        chk("midrst_vector", int_vector, 16'h0000);
        rd("midrst_if", 16'hFF0F, 8'hE0);
        rd("midrst_ie", 16'hFFFF, 8'h00);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
